ext_wb_arbiter: RTL and testbench

Write-back arbiter between the execution units and the register file. Collects `ext_arb_req_t` results from `NUM_SRC` producers (ALU, MUL/DIV, FPU, LSU, ...), grants one per cycle round-robin, formats the result (word sign-extension or NaN-boxing), and presents it on a single registered write port. On each completed write it pulses a one-hot unlock vector back to the instruction launcher, releasing the destination register's lock.

---
 rtl/maverickOne_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/ext_wb_arbiter.sv | 75 +++++++
 tb/tb_ext_wb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/maverickOne_pkg.sv
// Shared core types and widths used by the execution back-end.
package maverickOne_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned NUM_REGS = 64;
   localparam int unsigned RD_W     = $clog2(NUM_REGS);

   parameter int NUM_EXT_SRC = 4;

   typedef struct packed {
      logic [RD_W-1:0] rd;
      logic [XLEN-1:0] result;
      logic            word;
   } ext_arb_req_t;

   // Word results to GPRs are sign-extended; word results to FPRs are NaN-boxed.
   function automatic logic [XLEN-1:0] ext_format(input ext_arb_req_t r);
      logic [XLEN-1:0] v;
      v = r.result;
      if (r.word) begin
         if (r.rd < RD_W'(32)) v = {{32{r.result[31]}}, r.result[31:0]};
         else                  v = {32'hFFFF_FFFF, r.result[31:0]};
      end
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         i_req,
   input  logic                 i_en,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic [N-1:0]         o_gnt,
   output logic [$clog2(N)-1:0] o_gnt_idx
);

   localparam int unsigned IDX_W = $clog2(N);

   logic             w_found;
   logic [IDX_W-1:0] w_idx;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int off = 0; off < N; off++) begin
         w_idx = IDX_W'((int'(i_ptr) + off) % N);
         if (i_en && !w_found && i_req[w_idx]) begin
            w_found      = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_gnt_idx    = w_idx;
         end
      end
   end

endmodule

// File: rtl/ext_wb_arbiter.sv
// Write-back arbiter: round-robin grant, result formatting, one registered
// register-file write port and a same-cycle one-hot unlock back to the launcher.
module ext_wb_arbiter
   import maverickOne_pkg::*;
#(
   parameter int NUM_SRC = NUM_EXT_SRC
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  ext_arb_req_t [NUM_SRC-1:0] src_req_i,
   input  logic [NUM_SRC-1:0]         src_valid_i,
   output logic [NUM_SRC-1:0]         src_ready_o,
   output logic [RD_W-1:0]            wb_rd_o,
   output logic [XLEN-1:0]            wb_data_o,
   output logic                       wb_valid_o,
   input  logic                       wb_ready_i,
   output logic [NUM_REGS-1:0]        unlock_o
);

   localparam int unsigned IDX_W = $clog2(NUM_SRC);

   logic [IDX_W-1:0] r_rr_ptr;
   logic             r_wb_valid;
   logic [RD_W-1:0]  r_wb_rd;
   logic [XLEN-1:0]  r_wb_data;

   logic               w_can_load;
   logic [NUM_SRC-1:0] w_gnt;
   logic [IDX_W-1:0]   w_gnt_idx;
   logic [IDX_W-1:0]   w_next_ptr;
   logic               w_fire;
   logic               w_load;
   ext_arb_req_t       w_req;

   assign w_can_load = !r_wb_valid || wb_ready_i;

   rr_arbiter #(.N(NUM_SRC)) u_rr (
      .i_req     (src_valid_i),
      .i_en      (w_can_load && !rst_i),
      .i_ptr     (r_rr_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   assign src_ready_o = w_gnt;
   assign w_fire      = |w_gnt;
   assign w_req       = src_req_i[w_gnt_idx];
   // Writes to x0 consume the grant but never reach the register file.
   assign w_load      = w_fire && (w_req.rd != '0);
   assign w_next_ptr  = (w_gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr_ptr   <= '0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
      end else begin
         if (w_fire) r_rr_ptr <= w_next_ptr;
         if (w_load) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= w_req.rd;
            r_wb_data  <= ext_format(w_req);
         end else if (wb_ready_i) begin
            r_wb_valid <= 1'b0;
         end
      end
   end

   assign wb_valid_o = r_wb_valid;
   assign wb_rd_o    = r_wb_rd;
   assign wb_data_o  = r_wb_data;
   assign unlock_o   = (r_wb_valid && wb_ready_i && !rst_i) ? (NUM_REGS'(1) << r_wb_rd) : '0;

endmodule

// File: tb/tb_ext_wb_arbiter.sv
// Directed and random-traffic bench for ext_wb_arbiter with a write-order scoreboard.
module tb_ext_wb_arbiter;
   import maverickOne_pkg::*;

   localparam int NS = 4;

   typedef struct {
      logic [5:0]  rd;
      logic [63:0] data;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   ext_arb_req_t [NS-1:0] src_req;
   logic [NS-1:0]         src_valid;
   logic [NS-1:0]         src_ready;
   logic [5:0]            wb_rd;
   logic [63:0]           wb_data;
   logic                  wb_valid;
   logic                  wb_ready;
   logic [63:0]           unlock;

   int n_asserts = 0;
   int n_fail    = 0;

   exp_t q[$];
   logic [NS-1:0] pend;

   ext_wb_arbiter #(.NUM_SRC(NS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .src_req_i   (src_req),
      .src_valid_i (src_valid),
      .src_ready_o (src_ready),
      .wb_rd_o     (wb_rd),
      .wb_data_o   (wb_data),
      .wb_valid_o  (wb_valid),
      .wb_ready_i  (wb_ready),
      .unlock_o    (unlock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic ext_arb_req_t mk(input logic [5:0] rd, input logic [63:0] res, input logic w);
      ext_arb_req_t r;
      r.rd = rd; r.result = res; r.word = w;
      return r;
   endfunction

   // Independent formatting model for the scoreboard.
   function automatic logic [63:0] fmt(input ext_arb_req_t r);
      if (!r.word)     return r.result;
      if (r.rd >= 32)  return {32'hFFFF_FFFF, r.result[31:0]};
      return {{32{r.result[31]}}, r.result[31:0]};
   endfunction

   initial begin
      rst = 1'b1; src_valid = '0; wb_ready = 1'b0; pend = '0;
      for (int i = 0; i < NS; i++) src_req[i] = mk(6'd0, 64'd0, 1'b0);
      tick(); tick();
      chk("rst_valid", 64'(wb_valid), 64'd0);
      chk("rst_rd", 64'(wb_rd), 64'd0);
      chk("rst_data", wb_data, 64'd0);
      chk("rst_ready", 64'(src_ready), 64'd0);

      // Leave a write pending, then reset over it.
      rst = 1'b0;
      src_valid = 4'b0010; src_req[1] = mk(6'd7, 64'h11, 1'b0);
      #1 chk("pend_grant", 64'(src_ready), 64'b0010);
      tick();
      src_valid = '0;
      chk("pend_valid", 64'(wb_valid), 64'd1);
      chk("pend_rd", 64'(wb_rd), 64'd7);
      rst = 1'b1; wb_ready = 1'b1; src_valid = 4'hF;
      for (int i = 0; i < NS; i++) src_req[i] = mk(6'(10 + i), {32'hA5A5_0000, 32'(i)}, 1'b0);
      #1;
      chk("rst_mid_unlock", unlock, 64'd0);
      chk("rst_mid_ready", 64'(src_ready), 64'd0);
      tick();
      chk("rst2_valid", 64'(wb_valid), 64'd0);
      chk("rst2_rd", 64'(wb_rd), 64'd0);
      chk("rst2_data", wb_data, 64'd0);
      chk("rst2_unlock", unlock, 64'd0);
      rst = 1'b0;

      // Round-robin with everyone valid: 0,1,2,3,0.
      for (int k = 0; k < 5; k++) begin
         int g;
         g = k % NS;
         #1 chk("rr_grant", 64'(src_ready), 64'(1) << g);
         tick();
         chk("rr_valid", 64'(wb_valid), 64'd1);
         chk("rr_rd", 64'(wb_rd), 64'(10 + g));
         chk("rr_data", wb_data, {32'hA5A5_0000, 32'(g)});
         chk("rr_unlock", unlock, 64'(1) << (10 + g));
      end
      src_valid = '0;
      #1 chk("rr_idle_ready", 64'(src_ready), 64'd0);
      tick();
      chk("rr_drain", 64'(wb_valid), 64'd0);

      // Formatting through source 0.
      src_valid = 4'b0001;
      src_req[0] = mk(6'd5, 64'h1234_5678_8000_0001, 1'b1);
      #1 chk("fmt_grant", 64'(src_ready), 64'b0001);
      tick();
      chk("fmt_sext_rd", 64'(wb_rd), 64'd5);
      chk("fmt_sext_data", wb_data, 64'hFFFF_FFFF_8000_0001);
      src_req[0] = mk(6'd40, 64'h1234_5678_8000_0001, 1'b1);
      tick();
      chk("fmt_nan_rd", 64'(wb_rd), 64'd40);
      chk("fmt_nan_data", wb_data, 64'hFFFF_FFFF_8000_0001);
      src_req[0] = mk(6'd5, 64'h0000_0000_7FFF_FFFF, 1'b1);
      tick();
      chk("fmt_pos_data", wb_data, 64'h0000_0000_7FFF_FFFF);
      src_valid = '0;
      tick();
      chk("fmt_drain", 64'(wb_valid), 64'd0);

      // Backpressure with sources 1 and 2 (pointer is at 1).
      wb_ready = 1'b0;
      src_valid = 4'b0110;
      src_req[1] = mk(6'd20, 64'hAAAA_0000_0000_0020, 1'b0);
      src_req[2] = mk(6'd21, 64'hBBBB_0000_0000_0021, 1'b0);
      #1 chk("bp_first", 64'(src_ready), 64'b0010);
      tick();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_valid", 64'(wb_valid), 64'd1);
         chk("bp_rd", 64'(wb_rd), 64'd20);
         chk("bp_data", wb_data, 64'hAAAA_0000_0000_0020);
         chk("bp_ready", 64'(src_ready), 64'd0);
         chk("bp_unlock", unlock, 64'd0);
         tick();
      end
      wb_ready = 1'b1;
      #1;
      chk("bp_rel_unlock", unlock, 64'(1) << 20);
      chk("bp_rel_grant", 64'(src_ready), 64'b0100);
      tick();
      src_valid = '0;
      chk("bp_next_rd", 64'(wb_rd), 64'd21);
      chk("bp_next_data", wb_data, 64'hBBBB_0000_0000_0021);
      chk("bp_next_unlock", unlock, 64'(1) << 21);
      tick();
      chk("bp_drain", 64'(wb_valid), 64'd0);
      chk("bp_drain_unlock", unlock, 64'd0);

      // x0 write from source 3 (pointer is at 3).
      src_valid = 4'b1000;
      src_req[3] = mk(6'd0, 64'hDEAD, 1'b0);
      #1 chk("x0_grant", 64'(src_ready), 64'b1000);
      tick();
      chk("x0_valid", 64'(wb_valid), 64'd0);
      chk("x0_unlock", unlock, 64'd0);
      src_valid = 4'b1001;
      src_req[0] = mk(6'd9, 64'h99, 1'b0);
      #1 chk("x0_next_grant", 64'(src_ready), 64'b0001);
      tick();
      chk("x0_next_rd", 64'(wb_rd), 64'd9);
      chk("x0_next_valid", 64'(wb_valid), 64'd1);
      src_valid = 4'b1000;
      tick();
      src_valid = '0;
      tick();
      chk("pre_rnd_idle", 64'(wb_valid), 64'd0);

      // Random traffic, then a drain phase with no new requests.
      for (int cyc = 0; cyc < 260; cyc++) begin
         for (int i = 0; i < NS; i++) begin
            if (!pend[i] && cyc < 220 && $urandom_range(1, 0) == 1) begin
               pend[i] = 1'b1;
               src_req[i] = mk(6'($urandom_range(63, 0)), {$urandom, $urandom}, 1'($urandom_range(1, 0)));
            end
         end
         src_valid = pend;
         wb_ready = (cyc >= 220) ? 1'b1 : ($urandom_range(3, 0) != 0);
         #1;
         if (unlock != '0) begin
            if (q.size() == 0) chk("rnd_spurious_unlock", unlock, 64'd0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("rnd_unlock", unlock, 64'(1) << e.rd);
               chk("rnd_data", wb_data, e.data);
            end
         end
         chk("rnd_onehot", 64'($countones(src_ready) <= 1), 64'd1);
         for (int i = 0; i < NS; i++) begin
            if (src_ready[i] && src_valid[i]) begin
               if (src_req[i].rd != 6'd0) q.push_back('{rd: src_req[i].rd, data: fmt(src_req[i])});
               pend[i] = 1'b0;
            end
         end
         tick();
      end
      chk("rnd_queue_empty", 64'(q.size()), 64'd0);
      chk("rnd_end_valid", 64'(wb_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
